// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - denomination constants, refill index encoding and FSM states shared by the vend stages
package vend_pkg;

  localparam logic [6:0] DENOM_100 = 7'd100;
  localparam logic [6:0] DENOM_50  = 7'd50;
  localparam logic [6:0] DENOM_20  = 7'd20;
  localparam logic [6:0] DENOM_10  = 7'd10;
  localparam logic [6:0] DENOM_5   = 7'd5;

  localparam logic [2:0] IDX_100 = 3'd0;
  localparam logic [2:0] IDX_50  = 3'd1;
  localparam logic [2:0] IDX_20  = 3'd2;
  localparam logic [2:0] IDX_10  = 3'd3;
  localparam logic [2:0] IDX_5   = 3'd4;

  localparam int NUM_DENOM = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SELECT = 2'd1;
  localparam state_t ST_EMIT   = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic logic [6:0] denom_of(input logic [2:0] idx);
    case (idx)
      IDX_100: denom_of = DENOM_100;
      IDX_50:  denom_of = DENOM_50;
      IDX_20:  denom_of = DENOM_20;
      IDX_10:  denom_of = DENOM_10;
      IDX_5:   denom_of = DENOM_5;
      default: denom_of = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, note, completion and refill signals of the change dispenser
interface change_dispenser_if #(
  parameter int STOCKW = 8
);
  logic              chg_valid;
  logic              chg_ready;
  logic [15:0]       chg_amount;
  logic              note_valid;
  logic              note_ready;
  logic [6:0]        note_denom;
  logic              done_valid;
  logic              done_short;
  logic [15:0]       done_residual;
  logic              refill_valid;
  logic [2:0]        refill_sel;
  logic [STOCKW-1:0] refill_count;
  logic [4:0]        stock_low;

  modport master (
    output chg_valid, chg_amount, note_ready, refill_valid, refill_sel, refill_count,
    input  chg_ready, note_valid, note_denom, done_valid, done_short, done_residual, stock_low
  );

  modport slave (
    input  chg_valid, chg_amount, note_ready, refill_valid, refill_sel, refill_count,
    output chg_ready, note_valid, note_denom, done_valid, done_short, done_residual, stock_low
  );
endinterface

// File: rtl/denom_picker.sv
// rtl/denom_picker.sv - largest denomination not exceeding rem that still has stock
module denom_picker
  import vend_pkg::*;
(
  input  logic [15:0] rem,
  input  logic [4:0]  stock_nz,
  output logic        pick_valid,
  output logic [2:0]  pick_idx
);

  always_comb begin
    pick_valid = 1'b1;
    pick_idx   = IDX_100;
    if (rem >= 16'(DENOM_100) && stock_nz[IDX_100]) begin
      pick_idx = IDX_100;
    end else if (rem >= 16'(DENOM_50) && stock_nz[IDX_50]) begin
      pick_idx = IDX_50;
    end else if (rem >= 16'(DENOM_20) && stock_nz[IDX_20]) begin
      pick_idx = IDX_20;
    end else if (rem >= 16'(DENOM_10) && stock_nz[IDX_10]) begin
      pick_idx = IDX_10;
    end else if (rem >= 16'(DENOM_5) && stock_nz[IDX_5]) begin
      pick_idx = IDX_5;
    end else begin
      pick_valid = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy note-by-note change payout with per-denomination stock
module change_dispenser
  import vend_pkg::*;
#(
  parameter int STOCKW      = 8,
  parameter int RESET_STOCK = 10,
  parameter int LOW_MARK    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  change_dispenser_if.slave  bus
);

  localparam logic [STOCKW-1:0] RST_STOCK = STOCKW'(RESET_STOCK);
  localparam logic [STOCKW-1:0] LOW_LVL   = STOCKW'(LOW_MARK);
  localparam logic              RST_LOW   = (RST_STOCK <= LOW_LVL);

  state_t                       state_q, state_d;
  logic [15:0]                  rem_q, rem_d;
  logic [2:0]                   idx_q, idx_d;
  logic [6:0]                   note_denom_q, note_denom_d;
  logic [4:0][STOCKW-1:0]       stock_q, stock_d;
  logic [4:0]                   low_q, low_d;
  logic [4:0]                   stock_nz;
  logic                         pick_valid;
  logic [2:0]                   pick_idx;

  denom_picker u_picker (
    .rem        (rem_q),
    .stock_nz   (stock_nz),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    note_denom_d = note_denom_q;
    stock_d      = stock_q;
    for (int i = 0; i < NUM_DENOM; i++) begin
      stock_nz[i] = (stock_q[i] != '0);
      low_d[i]    = (stock_q[i] <= LOW_LVL);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.chg_valid) begin
          rem_d   = bus.chg_amount;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick_valid) begin
          idx_d        = pick_idx;
          note_denom_d = denom_of(pick_idx);
          state_d      = ST_EMIT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_EMIT: begin
        if (bus.note_ready) begin
          rem_d = rem_q - 16'(note_denom_q);
          // A refill may have emptied this counter after the pick; hold at zero.
          if (stock_q[idx_q] != '0) begin
            stock_d[idx_q] = stock_q[idx_q] - STOCKW'(1);
          end
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied last so a refill overrides a same-cycle decrement.
    if (bus.refill_valid && bus.refill_sel <= IDX_5) begin
      stock_d[bus.refill_sel] = bus.refill_count;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      idx_q        <= IDX_100;
      note_denom_q <= '0;
      stock_q      <= {NUM_DENOM{RST_STOCK}};
      low_q        <= {NUM_DENOM{RST_LOW}};
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      note_denom_q <= note_denom_d;
      stock_q      <= stock_d;
      low_q        <= low_d;
    end
  end

  assign bus.chg_ready     = (state_q == ST_IDLE);
  assign bus.note_valid    = (state_q == ST_EMIT);
  assign bus.note_denom    = note_denom_q;
  assign bus.done_valid    = (state_q == ST_DONE);
  assign bus.done_short    = (state_q == ST_DONE) && (rem_q != '0);
  assign bus.done_residual = (state_q == ST_DONE) ? rem_q : '0;
  assign bus.stock_low     = low_q;

endmodule
